// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, latched request fields, requester ids.
// Performance counters in dmem_arbiter are built only when DMEM_ARB_PERF_EN is defined.
package dmem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [2:0]            funct3;
  } arb_req_t;

  localparam logic ARB_CORE = 1'b0;
  localparam logic ARB_DMA  = 1'b1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on conflict the requester selected by ptr_i wins.
// Grants are only issued while advance_i is high.
module rr_arbiter2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  input  logic advance_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  always_comb begin
    gnt0_o = advance_i & req0_i & (~req1_i | ~ptr_i);
    gnt1_o = advance_i & req1_i & (~req0_i |  ptr_i);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core MEM stage and a DMA/debug master, one transaction
// at a time. Defining DMEM_ARB_PERF_EN adds saturating conflict/stall performance counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // core MEM stage
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [2:0]        core_funct3_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  // DMA / debug master
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  input  logic [2:0]        dma_funct3_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  // data memory
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [2:0]        mem_funct3_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // performance counters
  output logic [31:0]       perf_conflict_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_ptr_q, rr_ptr_d;
  arb_req_t   req_q, req_d;

  logic     idle;
  logic     conflict;
  logic     rsp_fire;
  logic     stall;
  arb_req_t core_fields;
  arb_req_t dma_fields;

  assign idle     = (state_q == IDLE);
  assign conflict = core_req_i & dma_req_i;

  rr_arbiter2 u_rr (
    .req0_i    (core_req_i),
    .req1_i    (dma_req_i),
    .ptr_i     (rr_ptr_q),
    .advance_i (idle),
    .gnt0_o    (core_gnt_o),
    .gnt1_o    (dma_gnt_o)
  );

  always_comb begin
    core_fields        = '0;
    core_fields.we     = core_we_i;
    core_fields.addr   = ARB_ADDR_W'(core_addr_i);
    core_fields.wdata  = ARB_DATA_W'(core_wdata_i);
    core_fields.funct3 = core_funct3_i;
    dma_fields         = '0;
    dma_fields.we      = dma_we_i;
    dma_fields.addr    = ARB_ADDR_W'(dma_addr_i);
    dma_fields.wdata   = ARB_DATA_W'(dma_wdata_i);
    dma_fields.funct3  = dma_funct3_i;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    req_d    = req_q;
    unique case (state_q)
      IDLE: begin
        if (core_gnt_o || dma_gnt_o) begin
          state_d = ISSUE;
          owner_d = dma_gnt_o ? ARB_DMA : ARB_CORE;
          req_d   = dma_gnt_o ? dma_fields : core_fields;
          // Pointer only moves on a real conflict, so a lone requester does not steal priority.
          if (conflict) begin
            rr_ptr_d = dma_gnt_o ? ARB_CORE : ARB_DMA;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= ARB_CORE;
      rr_ptr_q <= ARB_CORE;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      req_q    <= req_d;
    end
  end

  // Responses outside WAIT (e.g. one left over from before a reset) are dropped.
  assign rsp_fire = (state_q == WAIT) & mem_rvalid_i;

  always_comb begin
    core_rvalid_o = rsp_fire & (owner_q == ARB_CORE);
    dma_rvalid_o  = rsp_fire & (owner_q == ARB_DMA);
    core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    dma_rdata_o   = dma_rvalid_o ? mem_rdata_i : '0;
  end

  always_comb begin
    mem_req_o    = (state_q == ISSUE);
    mem_we_o     = req_q.we;
    mem_addr_o   = ADDR_W'(req_q.addr);
    mem_wdata_o  = DATA_W'(req_q.wdata);
    mem_funct3_o = req_q.funct3;
  end

  // The grant cycle also stalls: the load result only arrives with core_rvalid_o.
  assign stall        = core_req_i |
                        ((owner_q == ARB_CORE) & (state_q != IDLE) & ~core_rvalid_o);
  assign core_stall_o = stall;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (idle && conflict) begin
        conflict_cnt_q <= sat_inc(conflict_cnt_q);
      end
      if (stall) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

  assign perf_conflict_cnt_o = conflict_cnt_q;
  assign perf_stall_cnt_o    = stall_cnt_q;
`else
  assign perf_conflict_cnt_o = '0;
  assign perf_stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all outputs compared every
// cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        core_req_i = 0, core_we_i = 0;
  logic [31:0] core_addr_i = 0, core_wdata_i = 0;
  logic [2:0]  core_funct3_i = 0;
  logic        core_gnt_o, core_rvalid_o, core_stall_o;
  logic [31:0] core_rdata_o;
  logic        dma_req_i = 0, dma_we_i = 0;
  logic [31:0] dma_addr_i = 0, dma_wdata_i = 0;
  logic [2:0]  dma_funct3_i = 0;
  logic        dma_gnt_o, dma_rvalid_o;
  logic [31:0] dma_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [2:0]  mem_funct3_o;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic [31:0] perf_conflict_cnt_o, perf_stall_cnt_o;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .core_req_i          (core_req_i),
    .core_we_i           (core_we_i),
    .core_addr_i         (core_addr_i),
    .core_wdata_i        (core_wdata_i),
    .core_funct3_i       (core_funct3_i),
    .core_gnt_o          (core_gnt_o),
    .core_rvalid_o       (core_rvalid_o),
    .core_rdata_o        (core_rdata_o),
    .core_stall_o        (core_stall_o),
    .dma_req_i           (dma_req_i),
    .dma_we_i            (dma_we_i),
    .dma_addr_i          (dma_addr_i),
    .dma_wdata_i         (dma_wdata_i),
    .dma_funct3_i        (dma_funct3_i),
    .dma_gnt_o           (dma_gnt_o),
    .dma_rvalid_o        (dma_rvalid_o),
    .dma_rdata_o         (dma_rdata_o),
    .mem_req_o           (mem_req_o),
    .mem_we_o            (mem_we_o),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_funct3_o        (mem_funct3_o),
    .mem_gnt_i           (mem_gnt_i),
    .mem_rvalid_i        (mem_rvalid_i),
    .mem_rdata_i         (mem_rdata_i),
    .perf_conflict_cnt_o (perf_conflict_cnt_o),
    .perf_stall_cnt_o    (perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory must never answer while the request is still waiting for its grant.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(mem_req_o && mem_rvalid_i)) else $error("protocol: rvalid during request phase");
    end
  end

  // Reference model: at most one transaction in flight; records who owns it and whether the
  // memory has accepted it. Priority for a conflict goes to whoever lost the last conflict.
  logic        m_busy, m_who, m_acc, m_pref, m_we;
  logic [31:0] m_addr, m_wdata, m_conf, m_stall;
  logic [2:0]  m_f3;

  always @(negedge clk) begin : model
    logic e_cg, e_dg, e_rv, e_crv, e_drv, e_stall;
    logic [31:0] e_perf_c, e_perf_s;
    if (!rst_n) begin
      check("rst_mem_req", mem_req_o, 0);
      check("rst_mem_we", mem_we_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_wdata", mem_wdata_o, 0);
      check("rst_mem_f3", mem_funct3_o, 0);
      check("rst_stall", core_stall_o, 0);
      check("rst_core_rv", core_rvalid_o, 0);
      check("rst_dma_rv", dma_rvalid_o, 0);
      check("rst_perf_c", perf_conflict_cnt_o, 0);
      check("rst_perf_s", perf_stall_cnt_o, 0);
      m_busy = 0; m_who = 0; m_acc = 0; m_pref = 0;
      m_conf = 0; m_stall = 0;
    end else begin
      e_cg    = !m_busy && core_req_i && (!dma_req_i || !m_pref);
      e_dg    = !m_busy && dma_req_i && (!core_req_i || m_pref);
      e_rv    = m_busy && m_acc && mem_rvalid_i;
      e_crv   = e_rv && !m_who;
      e_drv   = e_rv && m_who;
      e_stall = core_req_i || (m_busy && !m_who && !e_crv);
`ifdef DMEM_ARB_PERF_EN
      e_perf_c = m_conf;
      e_perf_s = m_stall;
`else
      e_perf_c = 0;
      e_perf_s = 0;
`endif
      check("core_gnt", core_gnt_o, e_cg);
      check("dma_gnt", dma_gnt_o, e_dg);
      check("mem_req", mem_req_o, m_busy && !m_acc);
      check("core_rvalid", core_rvalid_o, e_crv);
      check("dma_rvalid", dma_rvalid_o, e_drv);
      check("core_rdata", core_rdata_o, e_crv ? mem_rdata_i : 32'h0);
      check("dma_rdata", dma_rdata_o, e_drv ? mem_rdata_i : 32'h0);
      check("core_stall", core_stall_o, e_stall);
      check("perf_conflict", perf_conflict_cnt_o, e_perf_c);
      check("perf_stall", perf_stall_cnt_o, e_perf_s);
      if (m_busy && !m_acc) begin
        check("mem_we", mem_we_o, m_we);
        check("mem_addr", mem_addr_o, m_addr);
        check("mem_wdata", mem_wdata_o, m_wdata);
        check("mem_f3", mem_funct3_o, m_f3);
      end
      if (!m_busy && core_req_i && dma_req_i) m_conf = m_conf + 1;
      if (e_stall) m_stall = m_stall + 1;
      if (e_cg || e_dg) begin
        m_busy  = 1; m_acc = 0; m_who = e_dg;
        m_we    = e_dg ? dma_we_i : core_we_i;
        m_addr  = e_dg ? dma_addr_i : core_addr_i;
        m_wdata = e_dg ? dma_wdata_i : core_wdata_i;
        m_f3    = e_dg ? dma_funct3_i : core_funct3_i;
        if (core_req_i && dma_req_i) m_pref = !e_dg;
      end else if (m_busy && !m_acc && mem_gnt_i) begin
        m_acc = 1;
      end else if (e_rv) begin
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    smp();
    tick();
    rst_n = 1;
  endtask

  // Starts in the drive window of an ISSUE cycle; ends in the drive window of the next IDLE.
  task automatic serve(input logic who, input logic [31:0] rd);
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = rd;
    smp();
    check("srv_owner_rv", who ? dma_rvalid_o : core_rvalid_o, 1);
    check("srv_other_rv", who ? core_rvalid_o : dma_rvalid_o, 0);
    check("srv_owner_rd", who ? dma_rdata_o : core_rdata_o, rd);
    check("srv_other_rd", who ? core_rdata_o : dma_rdata_o, 0);
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  initial begin
    int   pulses;
    logic out, cg_seen, dg_seen;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Core load, immediate mem grant, response one cycle later.
    core_req_i = 1; core_we_i = 0; core_addr_i = 32'h40; core_funct3_i = 3'b010;
    smp();
    check("t1_gnt", core_gnt_o, 1);
    check("t1_stall_c0", core_stall_o, 1);
    tick();
    core_req_i = 0; mem_gnt_i = 1;
    smp();
    check("t1_mem_req", mem_req_o, 1);
    check("t1_stall_c1", core_stall_o, 1);
    tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    smp();
    check("t1_rvalid", core_rvalid_o, 1);
    check("t1_rdata", core_rdata_o, 32'hDEADBEEF);
    check("t1_stall_c2", core_stall_o, 0);
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0;

    // Round-robin alternation; also exactly three conflict cycles since this reset.
    do_reset();
    core_req_i = 1; core_addr_i = 32'h80; dma_req_i = 1; dma_we_i = 0; dma_addr_i = 32'h200;
    smp();
    check("t2_core_first", core_gnt_o, 1);
    check("t2_dma_waits", dma_gnt_o, 0);
    tick();
    core_req_i = 0;
    serve(0, 32'h1111);
    smp();
    check("t2_dma_next", dma_gnt_o, 1);
    tick();
    dma_req_i = 0;
    serve(1, 32'h2222);
    core_req_i = 1; dma_req_i = 1;
    smp();
    check("t2_dma_first", dma_gnt_o, 1);
    check("t2_core_waits", core_gnt_o, 0);
    tick();
    dma_req_i = 0;
    serve(1, 32'h3333);
    smp();
    check("t2_core_after", core_gnt_o, 1);
    tick();
    core_req_i = 0;
    serve(0, 32'h4444);
    core_req_i = 1; dma_req_i = 1;
    smp();
    check("t2_core_again", core_gnt_o, 1);
    tick();
    core_req_i = 0;
    serve(0, 32'h5555);
    tick();
    dma_req_i = 0;
    serve(1, 32'h6666);
    smp();
`ifdef DMEM_ARB_PERF_EN
    check("t2_perf_conflict", perf_conflict_cnt_o, 3);
`else
    check("t2_perf_conflict", perf_conflict_cnt_o, 0);
`endif
    tick();

    // Memory grant withheld for five cycles.
    core_req_i = 1; core_we_i = 1; core_addr_i = 32'h3C; core_wdata_i = 32'hA5A5_A5A5;
    core_funct3_i = 3'b001;
    smp();
    tick();
    core_req_i = 0;
    for (int i = 0; i < 6; i++) begin
      mem_gnt_i = (i == 5);
      smp();
      check("t3_mem_req", mem_req_o, 1);
      check("t3_we", mem_we_o, 1);
      check("t3_addr", mem_addr_o, 32'h3C);
      check("t3_wdata", mem_wdata_o, 32'hA5A5_A5A5);
      check("t3_f3", mem_funct3_o, 3'b001);
      check("t3_stall", core_stall_o, 1);
      tick();
    end
    mem_gnt_i = 0; mem_rvalid_i = 1;
    smp();
    check("t3_stall_end", core_stall_o, 0);
    tick();
    mem_rvalid_i = 0;

    // DMA word store.
    dma_req_i = 1; dma_we_i = 1; dma_addr_i = 32'h100; dma_wdata_i = 32'h1234_5678;
    dma_funct3_i = 3'b010;
    smp();
    tick();
    dma_req_i = 0; mem_gnt_i = 1;
    smp();
    check("t4_we", mem_we_o, 1);
    check("t4_addr", mem_addr_o, 32'h100);
    check("t4_wdata", mem_wdata_o, 32'h1234_5678);
    check("t4_f3", mem_funct3_o, 3'b010);
    tick();
    mem_gnt_i = 0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_i = (k == 1);
      smp();
      pulses += int'(dma_rvalid_o);
      tick();
    end
    mem_rvalid_i = 0;
    check("t4_dma_pulses", pulses, 1);

    // Reset while waiting for the response; the late response must be dropped.
    core_req_i = 1; core_we_i = 0; core_addr_i = 32'h44;
    smp();
    tick();
    core_req_i = 0; mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0;
    smp();
    check("t5_stall_wait", core_stall_o, 1);
    tick();
    rst_n = 0;
    #1;
    check("t5_rst_stall", core_stall_o, 0);
    check("t5_rst_mem_req", mem_req_o, 0);
    check("t5_rst_addr", mem_addr_o, 0);
    smp();
    tick();
    rst_n = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
    smp();
    check("t5_late_rv", core_rvalid_o, 0);
    check("t5_late_rd", core_rdata_o, 0);
    tick();
    mem_rvalid_i = 0; mem_rdata_i = 0; core_req_i = 1;
    smp();
    check("t5_regrant", core_gnt_o, 1);
    tick();
    core_req_i = 0;
    serve(0, 32'h7777);

    // Randomized traffic with a random-latency memory.
    out = 0; cg_seen = 0; dg_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (cg_seen) core_req_i = 0;
      if (dg_seen) dma_req_i = 0;
      if (!core_req_i && $urandom_range(0, 2) == 0) begin
        core_req_i = 1; core_we_i = 1'($urandom); core_addr_i = $urandom;
        core_wdata_i = $urandom; core_funct3_i = 3'($urandom);
      end
      if (!dma_req_i && $urandom_range(0, 2) == 0) begin
        dma_req_i = 1; dma_we_i = 1'($urandom); dma_addr_i = $urandom;
        dma_wdata_i = $urandom; dma_funct3_i = 3'($urandom);
      end
      mem_gnt_i    = mem_req_o && ($urandom_range(0, 2) != 0);
      mem_rvalid_i = out && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = $urandom;
      smp();
      cg_seen = core_gnt_o;
      dg_seen = dma_gnt_o;
      if (mem_rvalid_i) out = 0;
      if (mem_req_o && mem_gnt_i) out = 1;
      tick();
    end
    core_req_i = 0; dma_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
